// File: rtl/insn_sequencer_if.sv
// rtl/insn_sequencer_if.sv - fetch bus and execute handshake bundle for insn_sequencer
interface insn_sequencer_if;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] insn;
  logic       ex_start;
  logic       exec_done;
  logic       branch_taken;
  logic [7:0] branch_target;

  modport master (
    output mem_req, mem_addr, insn, ex_start,
    input  mem_ack, mem_rdata, exec_done, branch_taken, branch_target
  );

  modport slave (
    input  mem_req, mem_addr, insn, ex_start,
    output mem_ack, mem_rdata, exec_done, branch_taken, branch_target
  );
endinterface

// File: rtl/insn_sequencer.sv
// rtl/insn_sequencer.sv - FETCH/DECODE/EXECUTE instruction sequencer with retired counter
// Halt-on-opcode-00 support is built only when WF8_HALT_EN is defined.
module insn_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  insn_sequencer_if.master     bus,
  output logic [7:0]           pc,
  output logic [CNT_W-1:0]     retired,
  output logic                 halted
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [7:0] ir;
  logic       mem_req_q;
  logic       ex_start_q;
`ifdef WF8_HALT_EN
  logic       halted_q;
`endif

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = pc;
  assign bus.insn     = ir;
  assign bus.ex_start = ex_start_q;

`ifdef WF8_HALT_EN
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // mem_req is held low through reset and rises on the first edge after release,
  // so the first fetch cycle is the first one with mem_req high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      ir         <= 8'h00;
      retired    <= '0;
      mem_req_q  <= 1'b0;
      ex_start_q <= 1'b0;
`ifdef WF8_HALT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (mem_req_q && bus.mem_ack) begin
            ir        <= bus.mem_rdata;
            pc        <= pc + 8'd1;
            mem_req_q <= 1'b0;
            state     <= DECODE;
`ifdef WF8_HALT_EN
            ex_start_q <= (bus.mem_rdata != 8'h00);
`else
            ex_start_q <= 1'b1;
`endif
          end else begin
            mem_req_q <= 1'b1;
          end
        end

        DECODE: begin
          ex_start_q <= 1'b0;
`ifdef WF8_HALT_EN
          if (ir == 8'h00) begin
            state    <= HALT;
            halted_q <= 1'b1;
            retired  <= retired + CNT_ONE;
          end else begin
            state <= EXECUTE;
          end
`else
          state <= EXECUTE;
`endif
        end

        EXECUTE: begin
          if (bus.exec_done) begin
            retired   <= retired + CNT_ONE;
            mem_req_q <= 1'b1;
            state     <= FETCH;
            if (bus.branch_taken) begin
              pc <= bus.branch_target;
            end
          end
        end

        HALT: begin
`ifdef WF8_HALT_EN
          mem_req_q  <= 1'b0;
          ex_start_q <= 1'b0;
`else
          // Unreachable in this build; recover to a fresh fetch.
          mem_req_q  <= 1'b1;
          ex_start_q <= 1'b0;
          state      <= FETCH;
`endif
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_insn_sequencer.sv
// tb/tb_insn_sequencer.sv - scoreboard bench for insn_sequencer (honours WF8_HALT_EN)
module tb_insn_sequencer;
  localparam int         CNT_W  = 4;
  localparam logic [7:0] RST_PC = 8'h00;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       pc;
  logic [CNT_W-1:0] retired;
  logic             halted;

  insn_sequencer_if bus();

  insn_sequencer #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .pc(pc), .retired(retired), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; int req_cycles; } fexp_t;
  typedef struct { logic [7:0] insn; logic [7:0] pc; } xexp_t;

  fexp_t fq[$];
  xexp_t xq[$];

  int vectors = 0;
  int miscompares = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT accepts a fetch or pulses ex_start.
  int         req_run = 0;
  logic [7:0] req_addr0 = 8'h00;
  bit         prev_ex = 1'b0;

  always @(negedge clk) begin
    fexp_t f;
    xexp_t x;
    if (rst_n !== 1'b1) begin
      req_run = 0;
      prev_ex = 1'b0;
    end else begin
      if (bus.mem_req) begin
        if (req_run == 0) req_addr0 = bus.mem_addr;
        req_run++;
      end
      if (bus.mem_req && bus.mem_ack) begin
        if (fq.size() == 0) begin
          check("fetch_unexpected", 1, 0);
        end else begin
          f = fq.pop_front();
          check("fetch_addr", bus.mem_addr, f.addr);
          check("fetch_addr_stable", req_addr0, f.addr);
          check("req_cycles", req_run, f.req_cycles);
        end
        req_run = 0;
      end else if (!bus.mem_req) begin
        req_run = 0;
      end
      if (bus.ex_start) begin
        check("ex_start_width", prev_ex, 0);
        if (xq.size() == 0) begin
          check("ex_start_unexpected", 1, 0);
        end else begin
          x = xq.pop_front();
          check("ex_insn", bus.insn, x.insn);
          check("ex_pc", pc, x.pc);
        end
      end
      prev_ex = bus.ex_start;
    end
  end

  task automatic do_fetch(input int ack_dly, input logic [7:0] data);
    for (int t = 0; t < 20 && !bus.mem_req; t++) begin
      @(posedge clk); #1;
    end
    if (!bus.mem_req) check("req_timeout", 0, 1);
    repeat (ack_dly) begin
      @(posedge clk); #1;
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    @(posedge clk); #1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'hA5;
  endtask

  task automatic do_exec(input int done_dly, input bit br_early, input bit br,
                         input logic [7:0] tgt, input logic [7:0] data, input logic [7:0] pc_exp);
    @(posedge clk); #1;
    repeat (done_dly) begin
      bus.mem_ack       = 1'b1;
      bus.mem_rdata     = 8'hEE;
      bus.branch_taken  = br_early;
      bus.branch_target = 8'h77;
      @(posedge clk); #1;
    end
    bus.mem_ack       = 1'b0;
    bus.exec_done     = 1'b1;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    check("ir_stable", bus.insn, data);
    check("pc_stable", pc, pc_exp);
    @(posedge clk); #1;
    bus.exec_done    = 1'b0;
    bus.branch_taken = 1'b0;
    exp_ret++;
    check("retired", retired, exp_ret);
    check("pc_after_exec", pc, br ? tgt : pc_exp);
  endtask

  task automatic run_insn(input int ack_dly, input logic [7:0] data, input int done_dly,
                          input bit br_early, input bit br, input logic [7:0] tgt,
                          input logic [7:0] addr);
    logic [7:0] nxt;
    nxt = addr + 8'd1;
    fq.push_back('{addr: addr, req_cycles: ack_dly + 1});
    xq.push_back('{insn: data, pc: nxt});
    do_fetch(ack_dly, data);
    do_exec(done_dly, br_early, br, tgt, data, nxt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = 8'h00;
    bus.exec_done     = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_insn", bus.insn, 8'h00);
    check("rst_retired", retired, 0);
    check("rst_halted", halted, 0);
    check("rst_ex_start", bus.ex_start, 0);
    check("rst_mem_req", bus.mem_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("req_after_reset", bus.mem_req, 1);
    check("addr_after_reset", bus.mem_addr, RST_PC);

    run_insn(0, 8'h35, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    run_insn(4, 8'h12, 2, 1'b0, 1'b0, 8'h00, 8'h01);
    run_insn(0, 8'hC3, 0, 1'b0, 1'b1, 8'hA0, 8'h02);
    run_insn(1, 8'h44, 3, 1'b1, 1'b0, 8'h00, 8'hA0);
    run_insn(0, 8'h90, 0, 1'b0, 1'b1, 8'hFF, 8'hA1);
    run_insn(0, 8'h21, 0, 1'b0, 1'b0, 8'h00, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      run_insn(i % 2, 8'(8'h60 + i), i % 3, 1'b0, 1'b0, 8'h00, 8'(i));
    end
    check("retired_wrap", retired, 0);

    // Reset pulled mid-EXECUTE at pc 0A.
    fq.push_back('{addr: 8'h0A, req_cycles: 1});
    xq.push_back('{insn: 8'h7E, pc: 8'h0B});
    do_fetch(0, 8'h7E);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", pc, RST_PC);
    check("mid_rst_insn", bus.insn, 8'h00);
    check("mid_rst_mem_req", bus.mem_req, 0);
    check("mid_rst_retired", retired, 0);
    check("mid_rst_halted", halted, 0);
    exp_ret = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("req_after_mid_rst", bus.mem_req, 1);
    check("addr_after_mid_rst", bus.mem_addr, RST_PC);
    run_insn(0, 8'h3C, 0, 1'b0, 1'b0, 8'h00, RST_PC);

`ifdef WF8_HALT_EN
    fq.push_back('{addr: 8'h01, req_cycles: 1});
    do_fetch(0, 8'h00);
    @(posedge clk); #1;
    exp_ret++;
    check("halt_retired", retired, exp_ret);
    for (int c = 0; c < 12; c++) begin
      check("halt_mem_req", bus.mem_req, 0);
      check("halt_ex_start", bus.ex_start, 0);
      @(posedge clk); #1;
    end
    check("halted", halted, 1);
`else
    run_insn(0, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h01);
    check("halted_tied", halted, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("fetch_queue_drained", fq.size(), 0);
    check("exec_queue_drained", xq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/insn_sequencer.md
INSN_SEQUENCER -- requirements
Module: insn_sequencer

Interface
REQ-001 Parameter RESET_PC, default 8'h00, is the program counter value loaded on reset.
REQ-002 Parameter CNT_W, default 16, is the width of the retired-instruction counter.
REQ-003 clk  input  1  is the single clock; all state changes occur on its rising edge.
REQ-004 rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 mem_req  output  1  is the instruction fetch request.
REQ-006 mem_addr  output  8  is the fetch address and SHALL equal pc.
REQ-007 mem_ack  input  1  indicates fetch data is valid; it is sampled only while mem_req=1.
REQ-008 mem_rdata  input  8  is the fetched instruction byte.
REQ-009 insn  output  8  is the instruction register (IR), which feeds the decoder.
REQ-010 ex_start  output  1  is a one-cycle pulse that starts datapath execution of insn.
REQ-011 exec_done  input  1  indicates the datapath has finished the current instruction; it is sampled only in EXECUTE.
REQ-012 branch_taken  input  1  qualifies exec_done with a redirect.
REQ-013 branch_target  input  8  is the redirect address.
REQ-014 pc  output  8  is the program counter.
REQ-015 retired  output  CNT_W  is the count of completed instructions.
REQ-016 halted  output  1  is high while in HALT.

Function
REQ-017 The FSM SHALL have the states FETCH, DECODE, EXECUTE and HALT, encoded in 2 bits.
REQ-018 In FETCH, mem_req SHALL be 1 and SHALL be held until mem_ack=1.
REQ-019 On mem_ack in FETCH: IR<=mem_rdata, pc<=pc+1 mod 256 (8'hFF wraps to 8'h00), next state DECODE.
REQ-020 mem_ack arriving in the first FETCH cycle SHALL be accepted, giving a zero-wait fetch.
REQ-021 mem_ack outside FETCH SHALL be ignored.
REQ-022 DECODE SHALL last exactly one cycle; ex_start=1 only in DECODE; next state EXECUTE.
REQ-023 EXECUTE SHALL hold until exec_done=1; IR and pc SHALL be stable throughout.
REQ-024 On exec_done with branch_taken=1: pc<=branch_target; otherwise pc is unchanged. Next state FETCH in both cases.
REQ-025 On exec_done, retired SHALL increment by 1 and wrap at 2^CNT_W.
REQ-026 branch_taken without exec_done SHALL have no effect.
REQ-027 The minimum instruction period SHALL be 3 cycles (FETCH, DECODE, EXECUTE with zero-wait ack and exec_done in the first EXECUTE cycle).
REQ-028 mem_req=0 and ex_start=0 in every state other than those named in REQ-018 and REQ-022.

Reset
REQ-029 While rst_n=0: state=FETCH, pc=RESET_PC, IR=8'h00, retired=0, halted=0, ex_start=0.
REQ-030 mem_req SHALL be 0 during reset and SHALL assert in the first cycle after deassertion.
REQ-031 Reset asserted mid-fetch or mid-execute SHALL abort immediately, with no IR, pc or retired update.

Configuration
REQ-032 The macro WF8_HALT_EN SHALL control halt support.
REQ-033 With WF8_HALT_EN defined, IR=8'h00 in DECODE SHALL go to HALT instead of EXECUTE, with no ex_start and retired+1.
REQ-034 In HALT: halted=1, mem_req=0, ex_start=0; HALT is left only by reset.
REQ-035 Without WF8_HALT_EN, 8'h00 SHALL execute as a normal instruction, the HALT state SHALL be unreachable, and halted SHALL be tied to 0.

Verification
REQ-036 Reset, then mem_ack=1 immediately with rdata=8'h35 and exec_done in the first EXECUTE cycle -> insn=8'h35, pc=8'h01, ex_start one pulse, retired=1 after 3 cycles.
REQ-037 mem_ack delayed 4 cycles -> mem_req held high 5 cycles, mem_addr=pc stable, IR captured only on the ack cycle.
REQ-038 exec_done with branch_taken=1 and branch_target=8'hA0 -> next mem_addr=8'hA0; branch_taken=1 without exec_done -> pc unchanged.
REQ-039 pc=8'hFF, fetch acked -> pc=8'h00; retired preloaded to 16'hFFFF, instruction retired -> retired=0.
REQ-040 rst_n pulled low mid-EXECUTE -> pc=RESET_PC, IR=0 and state FETCH asynchronously; a fetch resumes at RESET_PC.
REQ-041 WF8_HALT_EN defined, fetch 8'h00 -> halted=1, no ex_start, mem_req stays 0 for 10+ cycles; without the macro the same stimulus -> ex_start pulse.
